// File: rtl/hash_pkg.sv
// ---------------------------------------------------------------------------
// hash_pkg -- shared definitions for the hash round engine.
//   state_t    : FSM state encoding used by hash_round_engine
//   lane_arr_t : lane array for the default configuration (4 lanes x 8 bits)
// ---------------------------------------------------------------------------
package hash_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        CALC_SA    = 3'b001,
        CALC_ROUND = 3'b010,
        CALC_FINAL = 3'b011,
        DONE       = 3'b100
    } state_t;

    localparam int DEF_LANES = 4;
    localparam int DEF_W     = 8;

    typedef logic [DEF_LANES-1:0][DEF_W-1:0] lane_arr_t;

endpackage

// File: rtl/hash_round_fn.sv
// ---------------------------------------------------------------------------
// hash_round_fn -- one combinational round of the lane mixing function.
//   s      : current lane state (LANES x W)
//   r      : round counter, already sized to W bits
//   s_next : next lane state
// Each lane XORs itself with its right-hand neighbour, rotates left by
// (2i+1) mod W, and lane 0 additionally absorbs the round counter.
// ---------------------------------------------------------------------------
module hash_round_fn #(
    parameter int LANES = 4,
    parameter int W     = 8
) (
    input  logic [LANES-1:0][W-1:0] s,
    input  logic [W-1:0]            r,
    output logic [LANES-1:0][W-1:0] s_next
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int K  = (2 * i + 1) % W;
        localparam int NB = (i + 1) % LANES;

        logic [W-1:0] t_s;
        logic [W-1:0] rot_s;

        assign t_s = s[i] ^ s[NB];
        // A rotation amount of 0 (odd W dividing 2i+1) shifts right by W, which yields zero.
        assign rot_s = (t_s << K) | (t_s >> (W - K));

        if (i == 0) begin : g_inject
            assign s_next[i] = rot_s ^ r;
        end else begin : g_plain
            assign s_next[i] = rot_s;
        end
    end

endmodule

// File: rtl/hash_round_engine.sv
// ---------------------------------------------------------------------------
// hash_round_engine -- iterative lane-mixing hash engine.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : block handshake for H_in (message) and IV (chaining)
//   out_valid / out_ready: digest handshake for H_out
//   busy                 : high in every state except IDLE
// Flow: IDLE -> CALC_SA (s = H_in + IV) -> CALC_ROUND (ROUNDS cycles)
//       -> CALC_FINAL (load H_out) -> DONE (hold until out_ready) -> IDLE.
// Build option: HASH_ROUND_FEEDFORWARD_EN makes H_out = s ^ IV instead of s;
// latency and handshake are the same in both builds.
// ---------------------------------------------------------------------------
module hash_round_engine
    import hash_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int W      = 8,
    parameter int ROUNDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0][W-1:0]  H_in,
    input  logic [LANES-1:0][W-1:0]  IV,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0][W-1:0]  H_out,
    output logic                     busy
);

    // Counter is wide enough to hold ROUNDS, so it never wraps inside a block.
    localparam int             RW         = $clog2(ROUNDS) + 1;
    localparam logic [RW-1:0]  LAST_ROUND = RW'(ROUNDS - 1);

    state_t                     state_r;
    state_t                     state_n_s;
    logic                       in_ready_r;
    logic                       out_valid_r;
    logic                       busy_r;
    logic [RW-1:0]              round_r;
    logic [LANES-1:0][W-1:0]    hin_r;
    logic [LANES-1:0][W-1:0]    iv_r;
    logic [LANES-1:0][W-1:0]    s_r;
    logic [LANES-1:0][W-1:0]    h_out_r;
    logic [LANES-1:0][W-1:0]    sum_s;
    logic [LANES-1:0][W-1:0]    round_s;
    logic [LANES-1:0][W-1:0]    final_s;
    logic [W-1:0]               r_lane_s;

    // Present r[W-1:0] to the round function: truncate or zero-extend.
    if (RW >= W) begin : g_r_trunc
        assign r_lane_s = round_r[W-1:0];
    end else begin : g_r_ext
        assign r_lane_s = {{(W - RW){1'b0}}, round_r};
    end

    hash_round_fn #(
        .LANES (LANES),
        .W     (W)
    ) u_round_fn (
        .s      (s_r),
        .r      (r_lane_s),
        .s_next (round_s)
    );

    // Initial lane state: per-lane modular sum of message and chaining value.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_s[i] = hin_r[i] + iv_r[i];
        end
    end

    // Digest formation from the final lane state.
    always_comb begin
        final_s = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef HASH_ROUND_FEEDFORWARD_EN
            final_s[i] = s_r[i] ^ iv_r[i];
`else
            final_s[i] = s_r[i];
`endif
        end
    end

    // Next-state logic; in_valid is only looked at in IDLE, so busy states ignore it.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_n_s = CALC_SA;
                end else begin
                    state_n_s = IDLE;
                end
            end
            CALC_SA: begin
                state_n_s = CALC_ROUND;
            end
            CALC_ROUND: begin
                if (round_r == LAST_ROUND) begin
                    state_n_s = CALC_FINAL;
                end else begin
                    state_n_s = CALC_ROUND;
                end
            end
            CALC_FINAL: begin
                state_n_s = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = DONE;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // State register plus handshake flags, all registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            in_ready_r  <= (state_n_s == IDLE);
            out_valid_r <= (state_n_s == DONE);
            busy_r      <= (state_n_s != IDLE);
        end
    end

    // Datapath: input latching, lane state, round counter and digest register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hin_r   <= '0;
            iv_r    <= '0;
            s_r     <= '0;
            h_out_r <= '0;
            round_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        hin_r <= H_in;
                        iv_r  <= IV;
                    end else begin
                        hin_r <= hin_r;
                        iv_r  <= iv_r;
                    end
                end
                CALC_SA: begin
                    s_r     <= sum_s;
                    round_r <= '0;
                end
                CALC_ROUND: begin
                    s_r     <= round_s;
                    round_r <= round_r + {{(RW - 1){1'b0}}, 1'b1};
                end
                CALC_FINAL: begin
                    h_out_r <= final_s;
                end
                default: begin
                    h_out_r <= h_out_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign H_out     = h_out_r;

endmodule

// File: tb/tb_hash_round_engine.sv
// ---------------------------------------------------------------------------
// tb_hash_round_engine -- directed and random bench for hash_round_engine.
// Four instances with different LANES/W/ROUNDS are exercised one at a time.
// All lane data is carried in a common 8 x 16-bit container; expected
// digests are pushed to a queue when a block is driven and popped when the
// engine raises out_valid.
// ---------------------------------------------------------------------------
module tb_hash_round_engine;

    typedef logic [7:0][15:0] lanes_t;

`ifdef HASH_ROUND_FEEDFORWARD_EN
    localparam bit FF = 1'b1;
`else
    localparam bit FF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic   rst_n;
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;

    int     cfg_lanes  [4] = '{4, 4, 8, 5};
    int     cfg_w      [4] = '{8, 8, 16, 5};
    int     cfg_rounds [4] = '{1, 4, 12, 3};

    logic   in_valid_m  [4];
    logic   out_ready_m [4];
    lanes_t hin_m       [4];
    lanes_t iv_m        [4];
    lanes_t exp_q [$];

    // Instance A: 4 x 8, ROUNDS=1
    logic a_ir, a_ov, a_busy;
    logic [3:0][7:0] a_hin, a_iv, a_hout;
    // Instance B: default parameters (4 x 8, ROUNDS=4)
    logic b_ir, b_ov, b_busy;
    hash_pkg::lane_arr_t b_hin, b_iv, b_hout;
    // Instance C: 8 x 16, ROUNDS=12
    logic c_ir, c_ov, c_busy;
    logic [7:0][15:0] c_hout;
    // Instance D: 5 x 5, ROUNDS=3 (odd width, lane 2 rotates by zero)
    logic d_ir, d_ov, d_busy;
    logic [4:0][4:0] d_hin, d_iv, d_hout;

    for (genvar i = 0; i < 4; i++) begin : g_ab
        assign a_hin[i] = hin_m[0][i][7:0];
        assign a_iv[i]  = iv_m[0][i][7:0];
        assign b_hin[i] = hin_m[1][i][7:0];
        assign b_iv[i]  = iv_m[1][i][7:0];
    end
    for (genvar i = 0; i < 5; i++) begin : g_d
        assign d_hin[i] = hin_m[3][i][4:0];
        assign d_iv[i]  = iv_m[3][i][4:0];
    end

    hash_round_engine #(.LANES(4), .W(8), .ROUNDS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m[0]), .in_ready(a_ir),
        .H_in(a_hin), .IV(a_iv), .out_valid(a_ov), .out_ready(out_ready_m[0]),
        .H_out(a_hout), .busy(a_busy));

    hash_round_engine u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m[1]), .in_ready(b_ir),
        .H_in(b_hin), .IV(b_iv), .out_valid(b_ov), .out_ready(out_ready_m[1]),
        .H_out(b_hout), .busy(b_busy));

    hash_round_engine #(.LANES(8), .W(16), .ROUNDS(12)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m[2]), .in_ready(c_ir),
        .H_in(hin_m[2]), .IV(iv_m[2]), .out_valid(c_ov), .out_ready(out_ready_m[2]),
        .H_out(c_hout), .busy(c_busy));

    hash_round_engine #(.LANES(5), .W(5), .ROUNDS(3)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m[3]), .in_ready(d_ir),
        .H_in(d_hin), .IV(d_iv), .out_valid(d_ov), .out_ready(out_ready_m[3]),
        .H_out(d_hout), .busy(d_busy));

    function automatic logic get_ir(input int idx);
        case (idx)
            0: return a_ir;
            1: return b_ir;
            2: return c_ir;
            3: return d_ir;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic get_ov(input int idx);
        case (idx)
            0: return a_ov;
            1: return b_ov;
            2: return c_ov;
            3: return d_ov;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic get_busy(input int idx);
        case (idx)
            0: return a_busy;
            1: return b_busy;
            2: return c_busy;
            3: return d_busy;
            default: return 1'b0;
        endcase
    endfunction

    function automatic lanes_t get_hout(input int idx);
        lanes_t r;
        r = '0;
        case (idx)
            0: for (int i = 0; i < 4; i++) r[i][7:0] = a_hout[i];
            1: for (int i = 0; i < 4; i++) r[i][7:0] = b_hout[i];
            2: r = c_hout;
            3: for (int i = 0; i < 5; i++) r[i][4:0] = d_hout[i];
            default: r = '0;
        endcase
        return r;
    endfunction

    // Reference model of the whole block computation for instance idx.
    function automatic lanes_t model(input int idx, input lanes_t hin, input lanes_t iv);
        int          l;
        int          w;
        int          nr;
        int          k;
        logic [31:0] mask;
        logic [31:0] s [8];
        logic [31:0] n [8];
        logic [31:0] t;
        logic [31:0] v;
        lanes_t      res;
        l    = cfg_lanes[idx];
        w    = cfg_w[idx];
        nr   = cfg_rounds[idx];
        mask = (32'd1 << w) - 32'd1;
        res  = '0;
        for (int i = 0; i < 8; i++) begin
            s[i] = 32'd0;
            n[i] = 32'd0;
        end
        for (int i = 0; i < l; i++) begin
            s[i] = (({16'd0, hin[i]} & mask) + ({16'd0, iv[i]} & mask)) & mask;
        end
        for (int r = 0; r < nr; r++) begin
            for (int i = 0; i < l; i++) begin
                t    = s[i] ^ s[(i + 1) % l];
                k    = (2 * i + 1) % w;
                n[i] = ((t << k) | (t >> (w - k))) & mask;
            end
            n[0] = n[0] ^ (32'(r) & mask);
            for (int i = 0; i < l; i++) s[i] = n[i];
        end
        for (int i = 0; i < l; i++) begin
            v = FF ? (s[i] ^ ({16'd0, iv[i]} & mask)) : s[i];
            res[i] = v[15:0];
        end
        return res;
    endfunction

    function automatic lanes_t rand_lanes();
        lanes_t r;
        for (int i = 0; i < 8; i++) r[i] = 16'($urandom);
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_ready(input int idx);
        int n;
        n = 0;
        while (get_ir(idx) !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("in_ready_wait", 128'(get_ir(idx)), 128'd1);
    endtask

    // Offer one block and return the cycle stamp of the acceptance edge.
    task automatic send(input int idx, input lanes_t hin, input lanes_t iv, output int acc);
        hin_m[idx]      = hin;
        iv_m[idx]       = iv;
        in_valid_m[idx] = 1'b1;
        wait_ready(idx);
        tick();
        in_valid_m[idx] = 1'b0;
        acc = cyc;
    endtask

    // Wait for the digest, then check latency and value against the scoreboard.
    task automatic collect(input int idx, input int acc, input string tag);
        int     n;
        lanes_t e;
        n = 0;
        while (get_ov(idx) !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_out_valid"}, 128'(get_ov(idx)), 128'd1);
        check({tag, "_latency"}, 128'(cyc - acc), 128'(cfg_rounds[idx] + 2));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e = '1;
        end
        check(tag, get_hout(idx), e);
    endtask

    initial begin
        lanes_t h;
        lanes_t v;
        lanes_t e;
        int     acc;
        int     acc2;
        int     idx;
        int     nblk;

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_m[i]  = 1'b0;
            out_ready_m[i] = 1'b1;
            hin_m[i]       = '0;
            iv_m[i]        = '0;
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state of every instance
        for (int i = 0; i < 4; i++) begin
            check("rst_out_valid", 128'(get_ov(i)), 128'd0);
            check("rst_busy", 128'(get_busy(i)), 128'd0);
            check("rst_in_ready", 128'(get_ir(i)), 128'd1);
            check("rst_h_out", get_hout(i), '0);
        end

        // ROUNDS=1, message lane 0 = 01, IV = 0
        h = '0; h[0] = 16'h01; v = '0;
        e = '0; e[0] = 16'h02; e[3] = 16'h80;
        exp_q.push_back(e);
        send(0, h, v, acc);
        collect(0, acc, "r1_msg");

        // ROUNDS=1, message = 0, IV lane 0 = 01
        h = '0; v = '0; v[0] = 16'h01;
        e = '0; e[0] = FF ? 16'h03 : 16'h02; e[3] = 16'h80;
        exp_q.push_back(e);
        send(0, h, v, acc);
        collect(0, acc, "r1_iv");

        // in_valid held high: one acceptance, busy through compute, next block after handshake
        h = '0; h[0] = 16'h3c; h[1] = 16'ha5; h[2] = 16'h0f; h[3] = 16'hc3;
        v = '0; v[0] = 16'h11; v[2] = 16'h77;
        exp_q.push_back(model(1, h, v));
        hin_m[1] = h;
        iv_m[1]  = v;
        in_valid_m[1] = 1'b1;
        wait_ready(1);
        tick();
        acc = cyc;
        h[0] = 16'h99; h[3] = 16'h5a;
        hin_m[1] = h;
        for (int k = 0; k < 6; k++) begin
            check("hold_busy", 128'(get_busy(1)), 128'd1);
            check("hold_no_ready", 128'(get_ir(1)), 128'd0);
            tick();
        end
        collect(1, acc, "hold_first");
        exp_q.push_back(model(1, h, v));
        tick();
        check("hold_ready_after_hs", 128'(get_ir(1)), 128'd1);
        tick();
        acc2 = cyc;
        in_valid_m[1] = 1'b0;
        check("hold_throughput", 128'(acc2 - acc), 128'd8);
        collect(1, acc2, "hold_second");

        // Back-pressure in DONE for 10 cycles
        tick();
        out_ready_m[1] = 1'b0;
        h = '0; h[0] = 16'h12; h[1] = 16'h34; h[2] = 16'h56; h[3] = 16'h78;
        v = '0; v[1] = 16'hab; v[3] = 16'hcd;
        e = model(1, h, v);
        exp_q.push_back(e);
        send(1, h, v, acc);
        collect(1, acc, "bp_first");
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_out_valid", 128'(get_ov(1)), 128'd1);
            check("bp_h_out_stable", get_hout(1), e);
        end
        out_ready_m[1] = 1'b1;
        tick();
        check("bp_release_valid", 128'(get_ov(1)), 128'd0);
        check("bp_release_idle", 128'(get_ir(1)), 128'd1);
        check("bp_release_busy", 128'(get_busy(1)), 128'd0);

        // Reset during the second CALC_ROUND cycle abandons the block
        h = '0; h[0] = 16'hde; h[1] = 16'had; h[2] = 16'hbe; h[3] = 16'hef;
        v = '0; v[0] = 16'h01;
        hin_m[1] = h;
        iv_m[1]  = v;
        in_valid_m[1] = 1'b1;
        wait_ready(1);
        tick();
        in_valid_m[1] = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_out_valid", 128'(get_ov(1)), 128'd0);
        check("mid_rst_h_out", get_hout(1), '0);
        check("mid_rst_in_ready", 128'(get_ir(1)), 128'd1);
        check("mid_rst_busy", 128'(get_busy(1)), 128'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("mid_rst_no_digest", 128'(get_ov(1)), 128'd0);
        end
        exp_q.push_back(model(1, h, v));
        send(1, h, v, acc);
        collect(1, acc, "post_reset");

        // Random blocks on three configurations, 1000 on the 8/16/12 one
        for (int c = 0; c < 3; c++) begin
            idx  = (c == 0) ? 1 : ((c == 1) ? 3 : 2);
            nblk = (idx == 2) ? 1000 : 300;
            for (int b = 0; b < nblk; b++) begin
                repeat ($urandom_range(0, 2)) tick();
                h = rand_lanes();
                v = rand_lanes();
                exp_q.push_back(model(idx, h, v));
                send(idx, h, v, acc);
                collect(idx, acc, "random");
            end
            tick();
        end

        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hash_round_engine.md
HASH_ROUND_ENGINE -- requirements
Module: hash_round_engine

Interface
REQ-001 SHALL have parameter LANES, default 4, number of W-bit state lanes (>=2).
REQ-002 SHALL have parameter W, default 8, lane width in bits (>=4).
REQ-003 SHALL have parameter ROUNDS, default 4, round iterations per block (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  a block is offered on H_in and IV.
REQ-007 SHALL have port in_ready  output  1  block accepted on an edge where in_valid && in_ready.
REQ-008 SHALL have port H_in  input  [W-1:0] x LANES  message lanes.
REQ-009 SHALL have port IV  input  [W-1:0] x LANES  chaining value lanes.
REQ-010 SHALL have port out_valid  output  1  H_out holds a finished digest.
REQ-011 SHALL have port out_ready  input  1  consumer takes the digest.
REQ-012 SHALL have port H_out  output  [W-1:0] x LANES  registered digest lanes.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, CALC_SA, CALC_ROUND, CALC_FINAL and DONE, with the state encoding taken from the shared package.
REQ-015 SHALL drive in_ready=1 only in IDLE, and on acceptance SHALL latch H_in and IV into internal registers and go to CALC_SA.
REQ-016 SHALL, in CALC_SA, compute s[i] <= H_in_latched[i] + IV_latched[i] mod 2^W, clear the round counter r, and go to CALC_ROUND.
REQ-017 SHALL, in CALC_ROUND for each cycle, apply t[i] = s[i] ^ s[(i+1) mod LANES] and s[i] <= rotl(t[i], (2i+1) mod W), XOR r[W-1:0] into lane 0 only, then increment r.
REQ-018 SHALL stay in CALC_ROUND exactly ROUNDS cycles, leaving when r == ROUNDS-1; r SHALL have width $clog2(ROUNDS)+1 and SHALL never wrap mid-block.
REQ-019 SHALL, in CALC_FINAL, load H_out from s according to REQ-027/028 and go to DONE.
REQ-020 SHALL hold out_valid=1 in DONE with H_out stable until out_valid && out_ready, then return to IDLE on the next edge.
REQ-021 SHALL raise out_valid exactly ROUNDS+2 cycles after the acceptance edge when out_ready is not involved.
REQ-022 SHALL ignore in_valid while busy, with no latch and no state change.
REQ-023 SHALL not accept a new block in DONE; back-to-back throughput SHALL be one block per ROUNDS+4 cycles when out_ready is held at 1.

Reset
REQ-024 SHALL, when rst_n=0 at an edge, force state to IDLE, r to 0, s to 0, H_out to 0, out_valid to 0 and busy to 0, giving in_ready=1 after the first edge with rst_n=1.
REQ-025 SHALL, on reset in any state including mid-round, abandon the block with no digest emitted.
REQ-026 SHALL give reset priority over in_valid and out_ready on the same edge.

Configuration
REQ-027 SHALL, with HASH_ROUND_FEEDFORWARD_EN defined, set H_out[i] = s[i] ^ IV_latched[i] in CALC_FINAL.
REQ-028 SHALL, without HASH_ROUND_FEEDFORWARD_EN, set H_out[i] = s[i] in CALC_FINAL; latency and handshake SHALL be identical in both builds.

Structure
REQ-029 SHALL take the state enum (IDLE=3'b000, CALC_SA=3'b001, CALC_ROUND=3'b010, CALC_FINAL=3'b011, DONE=3'b100) and the lane-array typedef from package hash_pkg.
REQ-030 SHALL contain the combinational round function of REQ-017 in one sub-module, hash_round_fn, parametrised by LANES and W, taking s and r and returning the next s.

Verification
REQ-031 SHALL check that with LANES=4, W=8, ROUNDS=1, H_in={01,00,00,00} and IV=0 accepted, H_out={02,00,00,80} at out_valid, 3 cycles after acceptance.
REQ-032 SHALL check that with H_in=0 and IV={01,00,00,00} in the same configuration, H_out={03,00,00,80} with HASH_ROUND_FEEDFORWARD_EN and {02,00,00,80} without it.
REQ-033 SHALL check that with ROUNDS=4 and in_valid held high throughout, exactly one acceptance occurs, busy stays 1 for 6 cycles, and the second block is accepted only after the out_ready handshake.
REQ-034 SHALL check that with out_ready=0 for 10 cycles in DONE, out_valid stays 1 and H_out is unchanged; asserting out_ready then gives IDLE one edge later.
REQ-035 SHALL check that rst_n=0 for one edge during cycle 2 of CALC_ROUND leaves out_valid=0, H_out=0 and in_ready=1 next cycle, and that a following block yields the correct digest.
REQ-036 SHALL check that random LANES/W/ROUNDS configurations (e.g. 8/16/12) match the bench model of REQ-016 through REQ-019 for 1000 random blocks.
